// File: rtl/ddr2pe_router.sv
// DDR beat stream -> per-group ibuf/dbuf/pbuf write distributor (broadcast or round-robin).
// Optional DDR2PE_ROUTER_PERF_EN adds saturating stall_cnt/beat_cnt outputs.
module ddr2pe_router #(
  parameter int DDR_W     = 512,
  parameter int GRP_NUM   = 4,
  parameter int BUF_DEPTH = 256,
  parameter int CNT_W     = 16,
  localparam int AW       = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [1:0]         conf_dst,
  input  logic [GRP_NUM-1:0] conf_grp_mask,
  input  logic               conf_rr,
  input  logic [AW-1:0]      conf_base_addr,
  input  logic [CNT_W-1:0]   conf_beats,
  output logic               busy,
  output logic               done,
  input  logic [DDR_W-1:0]   ddr_data,
  input  logic               ddr_valid,
  output logic               ddr_ready,
  output logic [DDR_W-1:0]   wr_data,
  output logic [AW-1:0]      wr_addr,
  output logic [GRP_NUM-1:0] ibuf_wr_en,
  output logic [GRP_NUM-1:0] dbuf_wr_en,
`ifdef DDR2PE_ROUTER_PERF_EN
  output logic [31:0]        stall_cnt,
  output logic [31:0]        beat_cnt,
`endif
  output logic [GRP_NUM-1:0] pbuf_wr_en
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t             state, state_n;
  logic [1:0]         dst_q;
  logic [GRP_NUM-1:0] mask_q;
  logic               rr_q;
  logic [CNT_W-1:0]   beats_left;
  logic [AW-1:0]      addr_q;
  logic [GRP_NUM-1:0] ptr_q;

  logic               vld_p0;
  logic               last_p0;
  logic               cmd_p0;
  logic [GRP_NUM-1:0] above_p0;
  logic [GRP_NUM-1:0] en_p0;
  logic               adv_p0;

  function automatic logic [GRP_NUM-1:0] lowest(input logic [GRP_NUM-1:0] m);
    return m & (~m + GRP_NUM'(1));
  endfunction

  function automatic logic [AW-1:0] addr_inc(input logic [AW-1:0] a);
    return (a == AW'(BUF_DEPTH - 1)) ? '0 : a + AW'(1);
  endfunction

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == '1) ? v : v + 32'd1;
  endfunction

  assign busy      = (state != S_IDLE);
  assign ddr_ready = (state == S_RUN);
  assign done      = (state == S_DONE);

  assign cmd_p0  = (state == S_IDLE) && start;
  assign vld_p0  = (state == S_RUN) && ddr_valid;
  assign last_p0 = vld_p0 && (beats_left == CNT_W'(1));

  // Groups above the current round-robin pointer; none left means wrap to lowest and bump addr.
  assign above_p0 = mask_q & ~(ptr_q | (ptr_q - GRP_NUM'(1)));
  assign en_p0    = rr_q ? ptr_q : mask_q;
  assign adv_p0   = !rr_q || (above_p0 == '0);

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE: if (start) state_n = (conf_beats != '0) ? S_RUN : S_DONE;
      S_RUN:  if (last_p0) state_n = S_DONE;
      S_DONE: state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      dst_q      <= '0;
      mask_q     <= '0;
      rr_q       <= 1'b0;
      beats_left <= '0;
      addr_q     <= '0;
      ptr_q      <= '0;
    end else begin
      state <= state_n;
      if (cmd_p0) begin
        dst_q      <= conf_dst;
        mask_q     <= conf_grp_mask;
        rr_q       <= conf_rr;
        beats_left <= conf_beats;
        addr_q     <= conf_base_addr;
        ptr_q      <= lowest(conf_grp_mask);
      end else if (vld_p0) begin
        beats_left <= beats_left - CNT_W'(1);
        if (adv_p0) addr_q <= addr_inc(addr_q);
        if (rr_q) ptr_q <= (above_p0 != '0) ? lowest(above_p0) : lowest(mask_q);
      end
    end
  end

  // p0 -> p1: registered buffer write port, enables are single-cycle pulses
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_data    <= '0;
      wr_addr    <= '0;
      ibuf_wr_en <= '0;
      dbuf_wr_en <= '0;
      pbuf_wr_en <= '0;
    end else begin
      ibuf_wr_en <= '0;
      dbuf_wr_en <= '0;
      pbuf_wr_en <= '0;
      if (vld_p0) begin
        wr_data <= ddr_data;
        wr_addr <= addr_q;
        case (dst_q)
          2'd0:    ibuf_wr_en <= en_p0;
          2'd1:    dbuf_wr_en <= en_p0;
          2'd2:    pbuf_wr_en <= en_p0;
          default: ;
        endcase
      end
    end
  end

`ifdef DDR2PE_ROUTER_PERF_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt <= '0;
      beat_cnt  <= '0;
    end else if (cmd_p0) begin
      stall_cnt <= '0;
      beat_cnt  <= '0;
    end else begin
      if ((state == S_RUN) && !ddr_valid) stall_cnt <= sat_inc(stall_cnt);
      if (vld_p0) beat_cnt <= sat_inc(beat_cnt);
    end
  end
`endif

endmodule

// File: tb/tb_ddr2pe_router.sv
// Scoreboard bench for ddr2pe_router: directed commands push expected writes, a monitor pops them.
module tb_ddr2pe_router;
  localparam int DDR_W = 512, GRP_NUM = 4, BUF_DEPTH = 256, CNT_W = 16, AW = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0;
  logic [1:0] conf_dst = '0;
  logic [GRP_NUM-1:0] conf_grp_mask = '0;
  logic conf_rr = 1'b0;
  logic [AW-1:0] conf_base_addr = '0;
  logic [CNT_W-1:0] conf_beats = '0;
  logic busy, done, ddr_ready;
  logic [DDR_W-1:0] ddr_data = '0;
  logic ddr_valid = 1'b0;
  logic [DDR_W-1:0] wr_data;
  logic [AW-1:0] wr_addr;
  logic [GRP_NUM-1:0] ibuf_wr_en, dbuf_wr_en, pbuf_wr_en;
`ifdef DDR2PE_ROUTER_PERF_EN
  logic [31:0] stall_cnt, beat_cnt;
`endif

  ddr2pe_router #(.DDR_W(DDR_W), .GRP_NUM(GRP_NUM), .BUF_DEPTH(BUF_DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .start(start), .conf_dst(conf_dst), .conf_grp_mask(conf_grp_mask),
    .conf_rr(conf_rr), .conf_base_addr(conf_base_addr), .conf_beats(conf_beats),
    .busy(busy), .done(done), .ddr_data(ddr_data), .ddr_valid(ddr_valid), .ddr_ready(ddr_ready),
    .wr_data(wr_data), .wr_addr(wr_addr), .ibuf_wr_en(ibuf_wr_en), .dbuf_wr_en(dbuf_wr_en),
`ifdef DDR2PE_ROUTER_PERF_EN
    .stall_cnt(stall_cnt), .beat_cnt(beat_cnt),
`endif
    .pbuf_wr_en(pbuf_wr_en)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [GRP_NUM-1:0] ib, db, pb;
    logic [AW-1:0]      addr;
    logic [DDR_W-1:0]   data;
    logic               dn;
    logic               chk_wr;
  } exp_t;

  exp_t exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;

  function automatic logic [DDR_W-1:0] mk(input int k);
    logic [31:0] w;
    w = 32'hC0DE0000 ^ 32'(k);
    return {16{w}};
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, want);
    end
  endtask

  task automatic push(input logic [1:0] dst, input logic [GRP_NUM-1:0] en, input logic [AW-1:0] addr,
                      input logic [DDR_W-1:0] data, input logic dn, input logic chk_wr);
    exp_t e;
    e.ib = (dst == 2'd0) ? en : '0;
    e.db = (dst == 2'd1) ? en : '0;
    e.pb = (dst == 2'd2) ? en : '0;
    e.addr = addr; e.data = data; e.dn = dn; e.chk_wr = chk_wr;
    exp_q.push_back(e);
  endtask

  // Monitor: every cycle with a write enable or a done pulse consumes one expected entry.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst && ((|ibuf_wr_en) || (|dbuf_wr_en) || (|pbuf_wr_en) || done)) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_out: ib=%h db=%h pb=%h addr=%h done=%b with empty queue",
                   ibuf_wr_en, dbuf_wr_en, pbuf_wr_en, wr_addr, done);
        end else begin
          e = exp_q.pop_front();
          if (ibuf_wr_en !== e.ib || dbuf_wr_en !== e.db || pbuf_wr_en !== e.pb || done !== e.dn ||
              (e.chk_wr && (wr_addr !== e.addr || wr_data !== e.data))) begin
            n_bad++;
            $display("FAIL write: got ib=%h db=%h pb=%h addr=%h done=%b d0=%h, expected ib=%h db=%h pb=%h addr=%h done=%b d0=%h",
                     ibuf_wr_en, dbuf_wr_en, pbuf_wr_en, wr_addr, done, wr_data[31:0],
                     e.ib, e.db, e.pb, e.addr, e.dn, e.data[31:0]);
          end
        end
      end
    end
  end

  task automatic issue(input logic [1:0] dst, input logic [GRP_NUM-1:0] mask, input logic rr,
                       input logic [AW-1:0] base, input logic [CNT_W-1:0] beats);
    @(posedge clk); #1;
    start = 1'b1; conf_dst = dst; conf_grp_mask = mask; conf_rr = rr;
    conf_base_addr = base; conf_beats = beats;
    @(posedge clk); #1;
    start = 1'b0;
    conf_dst = ~dst; conf_grp_mask = ~mask; conf_rr = ~rr; conf_base_addr = ~base; conf_beats = 16'd7;
  endtask

  task automatic beat(input logic [DDR_W-1:0] d, input int gap);
    int n;
    ddr_valid = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
    ddr_valid = 1'b1; ddr_data = d;
    n = 0;
    while (!ddr_ready && n < 50) begin @(posedge clk); #1; n++; end
    if (!ddr_ready) chk("ready_timeout", 64'(ddr_ready), 64'd1);
    @(posedge clk); #1;
    ddr_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 100) begin @(posedge clk); #1; n++; end
    if (busy) chk("idle_timeout", 64'(busy), 64'd0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string name);
    chk(name, {busy, done, ddr_ready, ibuf_wr_en, dbuf_wr_en, pbuf_wr_en, wr_addr, (|wr_data)}, 64'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    #23;
    chk_all_zero("reset_state");
    @(negedge clk); rst = 1'b1;

    // Broadcast into dbuf
    push(2'd1, 4'hF, 8'h10, mk(1), 1'b0, 1'b1);
    push(2'd1, 4'hF, 8'h11, mk(2), 1'b0, 1'b1);
    push(2'd1, 4'hF, 8'h12, mk(3), 1'b1, 1'b1);
    issue(2'd1, 4'hF, 1'b0, 8'h10, 16'd3);
    for (int k = 1; k <= 3; k++) beat(mk(k), 0);
    wait_idle();

    // Round-robin over groups 1 and 3 into pbuf
    push(2'd2, 4'b0010, 8'd0, mk(11), 1'b0, 1'b1);
    push(2'd2, 4'b1000, 8'd0, mk(12), 1'b0, 1'b1);
    push(2'd2, 4'b0010, 8'd1, mk(13), 1'b0, 1'b1);
    push(2'd2, 4'b1000, 8'd1, mk(14), 1'b0, 1'b1);
    push(2'd2, 4'b0010, 8'd2, mk(15), 1'b1, 1'b1);
    issue(2'd2, 4'b1010, 1'b1, 8'd0, 16'd5);
    for (int k = 11; k <= 15; k++) beat(mk(k), 0);
    wait_idle();

    // Address wrap with a 2-cycle stall
    push(2'd0, 4'b0101, 8'd254, mk(21), 1'b0, 1'b1);
    push(2'd0, 4'b0101, 8'd255, mk(22), 1'b0, 1'b1);
    push(2'd0, 4'b0101, 8'd0,   mk(23), 1'b0, 1'b1);
    push(2'd0, 4'b0101, 8'd1,   mk(24), 1'b1, 1'b1);
    issue(2'd0, 4'b0101, 1'b0, 8'd254, 16'd4);
    beat(mk(21), 0);
    beat(mk(22), 0);
    beat(mk(23), 2);
    beat(mk(24), 0);
`ifdef DDR2PE_ROUTER_PERF_EN
    chk("stall_cnt", 64'(stall_cnt), 64'd2);
    chk("beat_cnt", 64'(beat_cnt), 64'd4);
`endif
    wait_idle();

    // Zero-beat command: done only, never ready
    push(2'd1, 4'h0, 8'd0, '0, 1'b1, 1'b0);
    issue(2'd1, 4'hF, 1'b0, 8'h05, 16'd0);
    chk("ready_zero_beats_c1", 64'(ddr_ready), 64'd0);
    @(posedge clk); #1;
    chk("ready_zero_beats_c2", 64'(ddr_ready), 64'd0);
    wait_idle();

    // Drop destination and empty mask: beats consumed, no enables
    push(2'd3, 4'h0, 8'd0, '0, 1'b1, 1'b0);
    issue(2'd3, 4'hF, 1'b0, 8'h08, 16'd2);
    beat(mk(31), 0); beat(mk(32), 0);
    wait_idle();
    push(2'd1, 4'h0, 8'd0, '0, 1'b1, 1'b0);
    issue(2'd1, 4'h0, 1'b1, 8'h08, 16'd2);
    beat(mk(33), 0); beat(mk(34), 0);
    wait_idle();

    // start during RUN is ignored
    push(2'd1, 4'b0011, 8'h40, mk(41), 1'b0, 1'b1);
    push(2'd1, 4'b0011, 8'h41, mk(42), 1'b0, 1'b1);
    push(2'd1, 4'b0011, 8'h42, mk(43), 1'b1, 1'b1);
    issue(2'd1, 4'b0011, 1'b0, 8'h40, 16'd3);
    beat(mk(41), 0);
    start = 1'b1; conf_dst = 2'd0; conf_grp_mask = 4'hC; conf_base_addr = 8'h90; conf_beats = 16'd1;
    beat(mk(42), 0);
    start = 1'b0;
    beat(mk(43), 0);
    wait_idle();

    // Reset after the first of four beats
    push(2'd0, 4'hF, 8'h20, mk(51), 1'b0, 1'b1);
    issue(2'd0, 4'hF, 1'b0, 8'h20, 16'd4);
    beat(mk(51), 0);
    @(negedge clk); #2;
    rst = 1'b0;
    #1;
    chk_all_zero("mid_cmd_reset");
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b1;

    // Fresh command after reset
    push(2'd2, 4'b0100, 8'h33, mk(61), 1'b0, 1'b1);
    push(2'd2, 4'b0100, 8'h34, mk(62), 1'b1, 1'b1);
    issue(2'd2, 4'b0100, 1'b0, 8'h33, 16'd2);
    beat(mk(61), 0); beat(mk(62), 0);
    wait_idle();

    repeat (3) @(posedge clk);
    #1;
    chk("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
